// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared types and constants for the serial feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_feeder_pkg;

   // PARITY is only reachable when SERIAL_FEEDER_PARITY_EN is defined
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_type;

   // level driven on serial_out whenever no bit is in flight
   localparam logic IDLE_LEVEL = 1'b0;

   // words leave the shifter most-significant bit first
   localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_feeder_bit_tick_counter.sv
// bit_tick_counter: counts clocks within one serial bit and flags the last one.
// Latency: rollover_flag is combinational from the count, high in clock CLKS_PER_BIT-1 of a bit.
// Backpressure: none; counts whenever enable is high, clear has priority.
module bit_tick_counter #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic rollover_flag
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TERMINAL = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   assign rollover_flag = enable && (count_q == TERMINAL);

   // next count: clear on word load, wrap to zero at terminal count
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = rollover_flag ? '0 : count_q + TW'(1);
      end
   end

   // tick count register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/serial_feeder.sv
// serial_feeder: MSB-first parallel-to-serial feeder with a one-word hold register.
// Latency: word accepted at edge k drives its MSB from cycle k+1; each bit lasts CLKS_PER_BIT clocks.
// Backpressure: load_ready = !hold_full; producer stalls until the shifter drains the hold word.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN appends an even-parity bit to every word.
module serial_feeder
   import serial_feeder_pkg::*;
#(
   parameter int NUM_BITS     = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [NUM_BITS-1:0] load_data,
   input  logic                load_valid,
   output logic                load_ready,
   output logic                serial_out,
   output logic                bit_strobe,
   output logic                word_done,
   output logic                busy
);

   localparam int BCW = $clog2(NUM_BITS + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(NUM_BITS - 1);

   state_type           state_q, state_d;
   logic [NUM_BITS-1:0] shift_q, shift_d;
   logic [NUM_BITS-1:0] hold_q, hold_d;
   logic                hold_full_q, hold_full_d;
   logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
   logic                strobe_q, strobe_d;
`ifdef SERIAL_FEEDER_PARITY_EN
   logic                parity_q, parity_d;
`endif

   logic                accept;
   logic                tick_done;
   logic                last_bit;
   logic                frame_end;
   logic                load_en;
   logic [NUM_BITS-1:0] load_word;
   logic                line_bit;

   assign accept   = load_valid && !hold_full_q;
   assign last_bit = (bit_cnt_q == LAST_BIT);
   assign line_bit = MSB_FIRST ? shift_q[NUM_BITS-1] : shift_q[0];

`ifdef SERIAL_FEEDER_PARITY_EN
   assign frame_end = (state_q == PARITY) && tick_done;
`else
   assign frame_end = (state_q == SHIFT) && tick_done && last_bit;
`endif

   bit_tick_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tick (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (load_en),
      .enable       (busy),
      .rollover_flag(tick_done)
   );

   // next-state: bit advance, frame end (hold drain or bypass), hold capture
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      strobe_d    = 1'b0;
      load_en     = 1'b0;
      load_word   = load_data;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_d    = parity_q;
`endif

      case (state_q)
         IDLE: begin
            if (accept) begin
               load_en = 1'b1;
            end
         end
         SHIFT: begin
            if (tick_done) begin
               if (!last_bit) begin
                  shift_d   = MSB_FIRST ? {shift_q[NUM_BITS-2:0], 1'b0}
                                        : {1'b0, shift_q[NUM_BITS-1:1]};
                  bit_cnt_d = bit_cnt_q + BCW'(1);
                  strobe_d  = 1'b1;
               end
`ifdef SERIAL_FEEDER_PARITY_EN
               else begin
                  state_d  = PARITY;
                  strobe_d = 1'b1;
               end
`endif
            end
         end
`ifdef SERIAL_FEEDER_PARITY_EN
         PARITY: begin
            // frame end is handled below
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // end of frame: the held word wins; an accept here cannot coexist with a full hold
      if (frame_end) begin
         if (hold_full_q) begin
            load_en     = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
         end else if (accept) begin
            load_en = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end

      // an accepted word the shifter cannot take right now waits in hold
      if (accept && !load_en) begin
         hold_d      = load_data;
         hold_full_d = 1'b1;
      end

      if (load_en) begin
         shift_d   = load_word;
         bit_cnt_d = '0;
         state_d   = SHIFT;
         strobe_d  = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_d  = ^load_word;
`endif
      end
   end

   // state, datapath and flag registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         strobe_q    <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         strobe_q    <= strobe_d;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   // line driver: current data bit, parity bit, or idle level
   always_comb begin
      serial_out = IDLE_LEVEL;
      case (state_q)
         SHIFT:   serial_out = line_bit;
`ifdef SERIAL_FEEDER_PARITY_EN
         PARITY:  serial_out = parity_q;
`endif
         default: serial_out = IDLE_LEVEL;
      endcase
   end

   assign load_ready = !hold_full_q;
   assign bit_strobe = strobe_q;
   assign word_done  = frame_end;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_feeder.sv
// tb_serial_feeder: drives two feeders (1 and 3 clocks per bit) from one stimulus stream.
// Latency: expected line activity comes from a per-cycle queue of bit records per instance.
// Backpressure: the model accepts a word only while at most one frame is still queued.
module tb_serial_feeder;

   localparam int NB   = 8;
   localparam int CPB0 = 1;
   localparam int CPB1 = 3;
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int FRAME = NB + 1;
`else
   localparam int FRAME = NB;
`endif

   typedef struct packed {
      logic ser;
      logic stb;
      logic done;
   } rec_t;

   typedef struct packed {
      logic          v;
      logic [NB-1:0] d;
      logic          ser;
      logic          stb;
      logic          done;
      logic          busy;
      logic          rdy;
   } vec_t;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          load_valid;
   logic [NB-1:0] load_data;
   logic [1:0]    rdy, ser, stb, done, busy;

   int   n_vec = 0;
   int   n_err = 0;
   rec_t mq [2][$];
   int   cpb [2];

   always #5 clk = ~clk;

   serial_feeder #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB0)) u_dut0 (
      .clk(clk), .n_rst(n_rst), .load_data(load_data), .load_valid(load_valid),
      .load_ready(rdy[0]), .serial_out(ser[0]), .bit_strobe(stb[0]),
      .word_done(done[0]), .busy(busy[0]));

   serial_feeder #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB1)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .load_data(load_data), .load_valid(load_valid),
      .load_ready(rdy[1]), .serial_out(ser[1]), .bit_strobe(stb[1]),
      .word_done(done[1]), .busy(busy[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset dut%0d serial_out", k), ser[k], 0);
         chk($sformatf("reset dut%0d bit_strobe", k), stb[k], 0);
         chk($sformatf("reset dut%0d word_done", k), done[k], 0);
         chk($sformatf("reset dut%0d busy", k), busy[k], 0);
         chk($sformatf("reset dut%0d load_ready", k), rdy[k], 1);
      end
   endtask

   // one frame = FRAME bits, each held cpb clocks; strobe on first clock, done on very last
   task automatic push_frame(input int k, input logic [NB-1:0] w);
      for (int b = 0; b < FRAME; b++) begin
         logic bv;
         bv = (b < NB) ? w[NB-1-b] : ^w;
         for (int t = 0; t < cpb[k]; t++) begin
            rec_t r;
            r.ser  = bv;
            r.stb  = (t == 0);
            r.done = (b == FRAME - 1) && (t == cpb[k] - 1);
            mq[k].push_back(r);
         end
      end
   endtask

   // called at a falling edge: check both instances, drive inputs, advance one clock
   task automatic cycle(input logic v, input logic [NB-1:0] d);
      logic [1:0] acc;
      for (int k = 0; k < 2; k++) begin
         rec_t e;
         logic eb;
         logic er;
         eb = (mq[k].size() != 0);
         e  = '0;
         if (eb) e = mq[k][0];
         er = (mq[k].size() <= FRAME * cpb[k]);
         chk($sformatf("dut%0d serial_out", k), ser[k], e.ser);
         chk($sformatf("dut%0d bit_strobe", k), stb[k], e.stb);
         chk($sformatf("dut%0d word_done", k), done[k], e.done);
         chk($sformatf("dut%0d busy", k), busy[k], eb);
         chk($sformatf("dut%0d load_ready", k), rdy[k], er);
         acc[k] = v && er;
      end
      load_valid = v;
      load_data  = d;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (mq[k].size() != 0) void'(mq[k].pop_front());
         if (acc[k]) push_frame(k, d);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (mq[0].size() == 0 && mq[1].size() == 0) break;
         cycle(1'b0, '0);
      end
   endtask

   initial begin
      vec_t          tbl [12];
      logic [0:11]   p_ser, p_busy, p_done;
      logic [NB-1:0] tw;
      int            d1, d2, rret, dc, ns, na;

      cpb[0] = CPB0;
      cpb[1] = CPB1;
`ifdef SERIAL_FEEDER_PARITY_EN
      tw     = 8'h07;
      p_ser  = 12'b0_00000111_1_00;
      p_busy = 12'b0_111111111_00;
      p_done = 12'b0_000000001_00;
`else
      tw     = 8'hD0;
      p_ser  = 12'b0_11010000_000;
      p_busy = 12'b0_11111111_000;
      p_done = 12'b0_00000001_000;
`endif
      for (int i = 0; i < 12; i++) begin
         tbl[i].v    = (i == 0);
         tbl[i].d    = (i == 0) ? tw : '0;
         tbl[i].ser  = p_ser[i];
         tbl[i].stb  = p_busy[i];
         tbl[i].done = p_done[i];
         tbl[i].busy = p_busy[i];
         tbl[i].rdy  = 1'b1;
      end

      n_rst      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      #2;
      chk_reset();
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      // single word on the 1-clock-per-bit instance against a fixed table
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("tbl[%0d] serial_out", i), ser[0], tbl[i].ser);
         chk($sformatf("tbl[%0d] bit_strobe", i), stb[0], tbl[i].stb);
         chk($sformatf("tbl[%0d] word_done", i), done[0], tbl[i].done);
         chk($sformatf("tbl[%0d] busy", i), busy[0], tbl[i].busy);
         chk($sformatf("tbl[%0d] load_ready", i), rdy[0], tbl[i].rdy);
         cycle(tbl[i].v, tbl[i].d);
      end

      // back-to-back words through the hold register
      drain();
      cycle(1'b1, 8'hDD);
      cycle(1'b1, 8'hB6);
      chk("b2b load_ready after second accept", rdy[0], 0);
      d1 = 0; d2 = 0; rret = 0;
      for (int c = 2; c <= 2 * FRAME + 4; c++) begin
         if (done[0]) begin
            if (d1 == 0) d1 = c;
            else if (d2 == 0) d2 = c;
         end
         if (rdy[0] && rret == 0) rret = c;
         cycle(1'b0, '0);
      end
      chk("b2b first word_done cycle", d1, FRAME);
      chk("b2b second word_done cycle", d2, 2 * FRAME);
      chk("b2b load_ready return cycle", rret, FRAME + 1);

      // three clocks per bit
      drain();
      cycle(1'b1, 8'hA5);
      dc = 0; ns = 0;
      for (int c = 1; c <= FRAME * CPB1 + 6; c++) begin
         if (done[1] && dc == 0) dc = c;
         if (stb[1]) ns++;
         cycle(1'b0, '0);
      end
      chk("cpb3 word_done cycle", dc, FRAME * CPB1);
      chk("cpb3 strobe count", ns, FRAME);

      // backpressure: hold full on the slow instance while valid stays high
      drain();
      cycle(1'b1, 8'h11);
      cycle(1'b1, 8'h22);
      na = 0;
      for (int c = 0; c < 10; c++) begin
         if (rdy[1]) na++;
         cycle(1'b1, 8'hFF);
      end
      chk("backpressure ready cycles dut1", na, 0);
      drain();

      // reset in the middle of a word with a word waiting in hold
      cycle(1'b1, 8'hF0);
      cycle(1'b1, 8'h3C);
      cycle(1'b0, '0);
      cycle(1'b0, '0);
      n_rst = 1'b0;
      #1;
      chk_reset();
      mq[0].delete();
      mq[1].delete();
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      for (int c = 0; c < 12; c++) cycle(1'b0, '0);

      // random traffic, alternating sparse and dense phases
      for (int c = 0; c < 600; c++) begin
         logic v;
         v = ($urandom_range(0, 99) < ((((c / 100) % 2) != 0) ? 85 : 30));
         cycle(v, NB'($urandom));
      end
      drain();
      cycle(1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
